img_buffer_ctl: RTL and testbench
=================================

# img_buffer_ctl

Frame-level scheduler for the optical-flow reference frame buffer. It watches the incoming pixel stream and decides, per frame, whether that frame overwrites the stored reference frame. It also tracks whether the stored reference is complete and trustworthy, and counts frame and framing errors. It sits beside the buffer on the same clock. Its `buf_we_en` gates the buffer's write enable, and its `cmp_valid` qualifies the flow stage's comparison results.

## Interface

Parameters:

- `PIXELS_BITS`, 20: width of the expected / counted beats-per-frame.
- `INTERVAL_BITS`, 8: width of the capture interval.
- `FRAME_CNT_BITS`, 32: width of the frame counter.
- `ERR_CNT_BITS`, 16: width of the error counter (saturating).

Ports:

- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk`, in, 1: clock.
  - `reset`, in, 1: synchronous, active-high.
- Stream monitor inputs, all 1 bit, all in:
  - `cke`: global clock enable. State holds when low.
  - `s_valid`, `s_de`: beat qualifiers.
  - `s_row_first`, `s_row_last`, `s_col_first`, `s_col_last`: frame position flags.
- Configuration and control inputs:
  - `cfg_pixels`, in, PIXELS_BITS: expected `de` beats per frame.
  - `cfg_interval`, in, INTERVAL_BITS: skip count between reference captures.
  - `cfg_freeze`, in, 1: hold the current reference; never capture.
  - `ref_clear`, in, 1: single-cycle pulse that invalidates the reference.
- Status and gating outputs:
  - `buf_we_en`, out, 1: the current frame is written into the buffer.
  - `ref_valid`, out, 1: the buffer holds one complete frame.
  - `cmp_valid`, out, 1: the current frame is compared against a valid reference.
  - `frame_start`, out, 1: pulse at the frame start beat.
  - `frame_end`, out, 1: pulse at the frame end beat.
  - `frame_count`, out, FRAME_CNT_BITS: number of frame starts.
  - `err_count`, out, ERR_CNT_BITS: number of framing errors (saturating).
  - `state`, out, 2: current FSM state.

## Operation

- Beats are sampled only when `cke` is high (`cke && s_valid`).
  - Start beat: `row_first && col_first`.
  - End beat: `row_last && col_last`.
  - Pixel counter: counts `de` beats from the start beat to the end beat, both inclusive. It saturates at its maximum value.
- States:
  - NO_REF (0): no valid reference.
  - FILL (1): capturing a frame while no valid reference exists.
  - READY (2): a valid reference is held.
  - UPDATE (3): capturing a new frame over a valid reference.
- Start beat, by state:
  - NO_REF → FILL. `buf_we_en`=1, `cmp_valid`=0.
  - READY with `cfg_freeze` high → stay in READY. `buf_we_en`=0, `cmp_valid`=1.
  - READY with interval counter == 0 → UPDATE. `buf_we_en`=1, `cmp_valid`=1.
  - READY with interval counter ≠ 0 → decrement the counter, stay in READY. `buf_we_en`=0, `cmp_valid`=1.
  - FILL or UPDATE (previous frame aborted) → increment `err_count`, drop `ref_valid`, go to FILL. `buf_we_en`=1, `cmp_valid`=0.
  - READY while a previous uncaptured frame is still open → increment `err_count`, then process as a normal READY start.
- End beat, pixel count equal to `cfg_pixels`:
  - FILL or UPDATE → READY. `ref_valid`=1 and the interval counter is loaded with `cfg_interval`.
  - READY → no change.
- End beat, pixel count not equal to `cfg_pixels`:
  - Always increment `err_count`.
  - FILL or UPDATE → NO_REF with `ref_valid`=0.
  - READY → reference untouched.
- `buf_we_en` clears at every end beat.
- UPDATE keeps `ref_valid`=1. The buffer reads before it writes at each address, so comparisons stay valid while the reference is being replaced.
- `ref_clear` has priority over all beat events in the same cycle. It forces NO_REF, `ref_valid`=0, `buf_we_en`=0, `cmp_valid`=0 and interval counter = 0. A start beat coincident with `ref_clear` is ignored, so that frame is not captured.
- `frame_count` increments on every start beat and wraps around.
- Configuration inputs are sampled only at start and end beats, so they may change mid-frame.

## Timing

- All outputs are registered. They update on the clock edge after the sampled beat, which aligns `buf_we_en` with the buffer's stage-0 write.
- `frame_start` and `frame_end` are one-cycle pulses that follow the beat by one cycle.
- With `cke` low: no state change, counters hold, pulses are forced to 0.
- Reset values of every output:
  - `state` = NO_REF.
  - `buf_we_en`, `ref_valid`, `cmp_valid`, `frame_start`, `frame_end` = 0.
  - `frame_count` = 0, `err_count` = 0.
- Internal state at reset: interval counter = 0, in-frame flag = 0, pixel counter = 0.
- Reset mid-frame abandons the frame. Beats before the next start beat are ignored and are not counted as errors.

## Structure

- Package `img_buffer_ctl_pkg`: the state enum (NO_REF, FILL, READY, UPDATE; 2 bits).
- One sub-module, `img_buffer_ctl_satcnt`: a parameterised saturating counter with `cke`, `clear` and `inc` inputs. It is used for the pixel counter and for `err_count`.

## Test plan

All frames are 4×4 with `cfg_pixels`=16.

- **Reset, then one clean frame:** `buf_we_en`=1 the cycle after the start beat, `state`=FILL. `ref_valid`=1 and `state`=READY the cycle after the end beat. `err_count`=0.
- **`cfg_interval`=2, seven frames:** `buf_we_en` is high only for frames 1, 4 and 7. `cmp_valid` is high for frames 2–7. `frame_count`=7.
- **FILL frame restarted at beat 10:** `err_count`=1, `ref_valid`=0, the new frame is captured, and READY is reached after its 16 beats.
- **UPDATE frame ending after 15 beats:** `state`=NO_REF, `ref_valid`=0, `err_count`=1. A 15-beat frame in READY without capture gives `err_count`=1 with `ref_valid` staying 1.
- **Freeze and clear:**
  - `cfg_freeze`=1 over three frames → `buf_we_en` never asserts.
  - `ref_clear` coincident with a start beat → NO_REF, that frame is not captured, and the next frame is captured (FILL).
- **`cke` toggling low for 3 cycles mid-frame:** pixel count and outputs are unchanged and the frame completes cleanly. Reset at beat 8 → all outputs at reset values, and no error is counted for the orphan end beat.

Source files
------------

// File: rtl/img_buffer_ctl_pkg.sv
// Shared definitions for the reference frame buffer scheduler.
// Contents:
//   buf_state_t : 2-bit FSM state encoding
//                 NO_REF (0), FILL (1), READY (2), UPDATE (3)
package img_buffer_ctl_pkg;

  typedef enum logic [1:0] {
    NO_REF = 2'd0,
    FILL   = 2'd1,
    READY  = 2'd2,
    UPDATE = 2'd3
  } buf_state_t;

endpackage

// File: rtl/img_buffer_ctl_satcnt.sv
// Saturating up-counter used for the per-frame pixel count and the error count.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, counter goes to 0
//   cke   : clock enable; the counter holds while low
//   clear : restart the count (this cycle's inc becomes the first count)
//   inc   : add one, sticking at the all-ones maximum
//   count : current count
module img_buffer_ctl_satcnt
  import img_buffer_ctl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cke,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  logic [WIDTH-1:0] count_next;

  // A clear restarts from zero but still honours an increment arriving in the
  // same cycle, so the first beat of a frame is counted by the clearing beat.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = inc ? WIDTH'(1) : '0;
    end else if (inc && (count != MAX_COUNT)) begin
      count_next = count + WIDTH'(1);
    end
  end

  // Counter register; clock enable freezes it completely.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (cke) begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/img_buffer_ctl.sv
// Frame-level scheduler for the optical-flow reference frame buffer.
// Watches the pixel stream, decides per frame whether it overwrites the stored
// reference, tracks whether the reference is complete, counts frames and errors.
// Ports:
//   clk, reset             : clock and synchronous active-high reset
//   cke                    : global clock enable, everything holds while low
//   s_valid, s_de          : beat qualifiers
//   s_row_first/last,
//   s_col_first/last       : frame position flags
//   cfg_pixels             : expected de beats per frame
//   cfg_interval           : frames skipped between reference captures
//   cfg_freeze             : hold the current reference, never capture
//   ref_clear              : pulse that invalidates the reference
//   buf_we_en              : current frame is written into the buffer
//   ref_valid              : buffer holds one complete frame
//   cmp_valid              : current frame is compared against a valid reference
//   frame_start, frame_end : one-cycle pulses after the start / end beat
//   frame_count            : number of frame starts (wraps)
//   err_count              : number of framing errors (saturates)
//   state                  : current FSM state
module img_buffer_ctl
  import img_buffer_ctl_pkg::*;
#(
  parameter int PIXELS_BITS    = 20,
  parameter int INTERVAL_BITS  = 8,
  parameter int FRAME_CNT_BITS = 32,
  parameter int ERR_CNT_BITS   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cke,
  input  logic                      s_valid,
  input  logic                      s_de,
  input  logic                      s_row_first,
  input  logic                      s_row_last,
  input  logic                      s_col_first,
  input  logic                      s_col_last,
  input  logic [PIXELS_BITS-1:0]    cfg_pixels,
  input  logic [INTERVAL_BITS-1:0]  cfg_interval,
  input  logic                      cfg_freeze,
  input  logic                      ref_clear,
  output logic                      buf_we_en,
  output logic                      ref_valid,
  output logic                      cmp_valid,
  output logic                      frame_start,
  output logic                      frame_end,
  output logic [FRAME_CNT_BITS-1:0] frame_count,
  output logic [ERR_CNT_BITS-1:0]   err_count,
  output logic [1:0]                state
);

  logic beat;
  logic start_beat;
  logic end_beat;
  logic start_ev;
  logic end_ev;
  logic pix_inc;
  logic pix_match;
  logic err_inc;

  buf_state_t state_q;
  buf_state_t state_mid;
  buf_state_t state_next;

  logic [INTERVAL_BITS-1:0] ival_q;
  logic [INTERVAL_BITS-1:0] ival_next;
  logic                     in_frame_q;
  logic                     in_frame_next;
  logic                     we_next;
  logic                     cmp_next;
  logic                     ref_next;

  logic [PIXELS_BITS-1:0] pix_count;
  logic [PIXELS_BITS-1:0] pix_base;
  logic [PIXELS_BITS-1:0] pix_total;

  // Beat decoding. A clear swallows every beat event in its cycle, and end
  // beats only count when a frame is actually open, so orphan end beats after
  // a reset or a clear are silently ignored.
  assign beat       = cke && s_valid;
  assign start_beat = beat && s_row_first && s_col_first;
  assign end_beat   = beat && s_row_last && s_col_last;
  assign start_ev   = start_beat && !ref_clear;
  assign end_ev     = end_beat && !ref_clear && (in_frame_q || start_ev);
  assign pix_inc    = beat && s_de && !ref_clear && (in_frame_q || start_ev);

  // Pixel total including the current beat, so the end beat can be judged in
  // the same cycle it arrives. Mirrors the counter's saturating update.
  always_comb begin
    pix_base  = start_ev ? '0 : pix_count;
    pix_total = pix_base;
    if (pix_inc && (pix_base != '1)) begin
      pix_total = pix_base + PIXELS_BITS'(1);
    end
  end

  assign pix_match = (pix_total == cfg_pixels);

  img_buffer_ctl_satcnt #(
    .WIDTH(PIXELS_BITS)
  ) u_pix_cnt (
    .clk  (clk),
    .reset(reset),
    .cke  (cke),
    .clear(start_ev),
    .inc  (pix_inc),
    .count(pix_count)
  );

  img_buffer_ctl_satcnt #(
    .WIDTH(ERR_CNT_BITS)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .cke  (cke),
    .clear(1'b0),
    .inc  (err_inc),
    .count(err_count)
  );

  // State register plus all registered outputs. Pulses are derived from the
  // cke-qualified beat events, so they fall to zero whenever cke is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= NO_REF;
      ival_q      <= '0;
      in_frame_q  <= 1'b0;
      buf_we_en   <= 1'b0;
      ref_valid   <= 1'b0;
      cmp_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= start_ev;
      frame_end   <= end_ev;
      if (cke) begin
        state_q    <= state_next;
        ival_q     <= ival_next;
        in_frame_q <= in_frame_next;
        buf_we_en  <= we_next;
        ref_valid  <= ref_next;
        cmp_valid  <= cmp_next;
        if (start_ev) begin
          frame_count <= frame_count + FRAME_CNT_BITS'(1);
        end
      end
    end
  end

  // Next-state logic. The start beat is applied first (state_mid), then the
  // end beat on top of it, which keeps a single-beat frame consistent.
  always_comb begin
    state_mid = state_q;
    if (start_ev) begin
      case (state_q)
        READY: begin
          if (cfg_freeze || (ival_q != '0)) begin
            state_mid = READY;
          end else begin
            state_mid = UPDATE;
          end
        end
        default: state_mid = FILL;
      endcase
    end
    state_next = state_mid;
    if (end_ev && ((state_mid == FILL) || (state_mid == UPDATE))) begin
      state_next = pix_match ? READY : NO_REF;
    end
    if (ref_clear) begin
      state_next = NO_REF;
    end
  end

  // Next values of the gating outputs, interval counter, in-frame flag and the
  // error increment. A start beat in READY with a frame still open means the
  // previous uncaptured frame never ended, which is also a framing error.
  always_comb begin
    we_next       = buf_we_en;
    cmp_next      = cmp_valid;
    ref_next      = ref_valid;
    ival_next     = ival_q;
    in_frame_next = in_frame_q;
    err_inc       = 1'b0;
    if (ref_clear) begin
      we_next       = 1'b0;
      cmp_next      = 1'b0;
      ref_next      = 1'b0;
      ival_next     = '0;
      in_frame_next = 1'b0;
    end else begin
      if (start_ev) begin
        in_frame_next = 1'b1;
        case (state_q)
          NO_REF: begin
            we_next  = 1'b1;
            cmp_next = 1'b0;
          end
          READY: begin
            err_inc  = in_frame_q;
            cmp_next = 1'b1;
            if (cfg_freeze) begin
              we_next = 1'b0;
            end else if (ival_q == '0) begin
              we_next = 1'b1;
            end else begin
              we_next   = 1'b0;
              ival_next = ival_q - INTERVAL_BITS'(1);
            end
          end
          default: begin
            err_inc  = 1'b1;
            ref_next = 1'b0;
            we_next  = 1'b1;
            cmp_next = 1'b0;
          end
        endcase
      end
      if (end_ev) begin
        in_frame_next = 1'b0;
        we_next       = 1'b0;
        if (!pix_match) begin
          err_inc = 1'b1;
        end
        if ((state_mid == FILL) || (state_mid == UPDATE)) begin
          if (pix_match) begin
            ref_next  = 1'b1;
            ival_next = cfg_interval;
          end else begin
            ref_next = 1'b0;
          end
        end
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_img_buffer_ctl.sv
// Directed testbench for img_buffer_ctl using 4x4 frames (16 pixels).
module tb_img_buffer_ctl;

  localparam int PB = 20;
  localparam int IB = 8;
  localparam int FB = 32;
  localparam int EB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cke;
  logic          s_valid;
  logic          s_de;
  logic          s_row_first;
  logic          s_row_last;
  logic          s_col_first;
  logic          s_col_last;
  logic [PB-1:0] cfg_pixels;
  logic [IB-1:0] cfg_interval;
  logic          cfg_freeze;
  logic          ref_clear;
  logic          buf_we_en;
  logic          ref_valid;
  logic          cmp_valid;
  logic          frame_start;
  logic          frame_end;
  logic [FB-1:0] frame_count;
  logic [EB-1:0] err_count;
  logic [1:0]    state;

  int tests_run = 0;
  int tests_failed = 0;

  logic          we_at_start;
  logic          cmp_at_start;
  logic          ref_at_start;
  logic          fs_at_start;
  logic [1:0]    st_at_start;
  logic [EB-1:0] err_at_start;

  img_buffer_ctl #(
    .PIXELS_BITS(PB),
    .INTERVAL_BITS(IB),
    .FRAME_CNT_BITS(FB),
    .ERR_CNT_BITS(EB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cke(cke),
    .s_valid(s_valid),
    .s_de(s_de),
    .s_row_first(s_row_first),
    .s_row_last(s_row_last),
    .s_col_first(s_col_first),
    .s_col_last(s_col_last),
    .cfg_pixels(cfg_pixels),
    .cfg_interval(cfg_interval),
    .cfg_freeze(cfg_freeze),
    .ref_clear(ref_clear),
    .buf_we_en(buf_we_en),
    .ref_valid(ref_valid),
    .cmp_valid(cmp_valid),
    .frame_start(frame_start),
    .frame_end(frame_end),
    .frame_count(frame_count),
    .err_count(err_count),
    .state(state)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stream inputs, then sample just after the edge.
  task automatic applyStimulus(input logic v, input logic de, input logic rf, input logic rl,
                               input logic cf, input logic cl, input logic clr);
    s_valid = v;
    s_de = de;
    s_row_first = rf;
    s_row_last = rl;
    s_col_first = cf;
    s_col_last = cl;
    ref_clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_valid = 1'b0;
    s_de = 1'b0;
    s_row_first = 1'b0;
    s_row_last = 1'b0;
    s_col_first = 1'b0;
    s_col_last = 1'b0;
    ref_clear = 1'b0;
  endtask

  // Send beats first_idx..last_idx of a 4x4 raster; force_end marks the last beat as the end beat.
  task automatic send_beats(input int first_idx, input int last_idx, input bit force_end);
    for (int k = first_idx; k <= last_idx; k++) begin
      logic rf, rl, cf, cl;
      rf = ((k / 4) == 0);
      rl = ((k / 4) == 3);
      cf = ((k % 4) == 0);
      cl = ((k % 4) == 3);
      if (force_end && (k == last_idx)) begin
        rl = 1'b1;
        cl = 1'b1;
      end
      applyStimulus(1'b1, 1'b1, rf, rl, cf, cl, 1'b0);
      if (k == first_idx) begin
        we_at_start = buf_we_en;
        cmp_at_start = cmp_valid;
        ref_at_start = ref_valid;
        fs_at_start = frame_start;
        st_at_start = state;
        err_at_start = err_count;
      end
    end
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cke = 1'b1;
    cfg_pixels = PB'(16);
    cfg_interval = '0;
    cfg_freeze = 1'b0;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tests_run++;
    if (state !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    tests_run++;
    if ({buf_we_en, ref_valid, cmp_valid, frame_start, frame_end} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {buf_we_en, ref_valid, cmp_valid, frame_start, frame_end});
    end
    tests_run++;
    if (frame_count !== '0 || err_count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_counts: got frames %0d errs %0d expected 0 0", frame_count, err_count);
    end
  endtask

  task automatic test_clean_frame();
    do_reset();
    send_beats(0, 15, 1'b0);
    tests_run++;
    if (we_at_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL clean_we: got %b expected 1", we_at_start); end
    tests_run++;
    if (st_at_start !== 2'd1) begin tests_failed++; $display("[TB] FAIL clean_fill: got %0d expected 1", st_at_start); end
    tests_run++;
    if (fs_at_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL clean_fstart: got %b expected 1", fs_at_start); end
    tests_run++;
    if (state !== 2'd2 || ref_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clean_ready: got state %0d ref %b expected 2 1", state, ref_valid);
    end
    tests_run++;
    if (frame_end !== 1'b1 || buf_we_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clean_end: got fend %b we %b expected 1 0", frame_end, buf_we_en);
    end
    tests_run++;
    if (err_count !== '0 || frame_count !== FB'(1)) begin
      tests_failed++;
      $display("[TB] FAIL clean_counts: got errs %0d frames %0d expected 0 1", err_count, frame_count);
    end
  endtask

  task automatic test_interval();
    logic [6:0] exp_we;
    logic [6:0] exp_cmp;
    exp_we = 7'b1001001;
    exp_cmp = 7'b1111110;
    do_reset();
    cfg_interval = IB'(2);
    for (int f = 0; f < 7; f++) begin
      send_beats(0, 15, 1'b0);
      tests_run++;
      if (we_at_start !== exp_we[f]) begin
        tests_failed++;
        $display("[TB] FAIL interval_we frame %0d: got %b expected %b", f + 1, we_at_start, exp_we[f]);
      end
      tests_run++;
      if (cmp_at_start !== exp_cmp[f]) begin
        tests_failed++;
        $display("[TB] FAIL interval_cmp frame %0d: got %b expected %b", f + 1, cmp_at_start, exp_cmp[f]);
      end
    end
    tests_run++;
    if (frame_count !== FB'(7) || err_count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL interval_counts: got frames %0d errs %0d expected 7 0", frame_count, err_count);
    end
    cfg_interval = '0;
  endtask

  task automatic test_fill_restart();
    do_reset();
    send_beats(0, 9, 1'b0);
    send_beats(0, 15, 1'b0);
    tests_run++;
    if (st_at_start !== 2'd1 || ref_at_start !== 1'b0 || we_at_start !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL restart_start: got state %0d ref %b we %b expected 1 0 1", st_at_start, ref_at_start, we_at_start);
    end
    tests_run++;
    if (err_at_start !== EB'(1)) begin tests_failed++; $display("[TB] FAIL restart_err: got %0d expected 1", err_at_start); end
    tests_run++;
    if (state !== 2'd2 || ref_valid !== 1'b1 || err_count !== EB'(1)) begin
      tests_failed++;
      $display("[TB] FAIL restart_done: got state %0d ref %b errs %0d expected 2 1 1", state, ref_valid, err_count);
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    send_beats(0, 15, 1'b0);
    send_beats(0, 14, 1'b1);
    tests_run++;
    if (st_at_start !== 2'd3 || ref_at_start !== 1'b1 || cmp_at_start !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL short_update: got state %0d ref %b cmp %b expected 3 1 1", st_at_start, ref_at_start, cmp_at_start);
    end
    tests_run++;
    if (state !== 2'd0 || ref_valid !== 1'b0 || err_count !== EB'(1)) begin
      tests_failed++;
      $display("[TB] FAIL short_update_end: got state %0d ref %b errs %0d expected 0 0 1", state, ref_valid, err_count);
    end
    do_reset();
    cfg_interval = IB'(5);
    send_beats(0, 15, 1'b0);
    send_beats(0, 14, 1'b1);
    tests_run++;
    if (st_at_start !== 2'd2 || we_at_start !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL short_skip_start: got state %0d we %b expected 2 0", st_at_start, we_at_start);
    end
    tests_run++;
    if (state !== 2'd2 || ref_valid !== 1'b1 || err_count !== EB'(1)) begin
      tests_failed++;
      $display("[TB] FAIL short_skip_end: got state %0d ref %b errs %0d expected 2 1 1", state, ref_valid, err_count);
    end
    cfg_interval = '0;
  endtask

  task automatic test_freeze_clear();
    do_reset();
    send_beats(0, 15, 1'b0);
    cfg_freeze = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_beats(0, 15, 1'b0);
      tests_run++;
      if (we_at_start !== 1'b0 || st_at_start !== 2'd2) begin
        tests_failed++;
        $display("[TB] FAIL freeze frame %0d: got we %b state %0d expected 0 2", f, we_at_start, st_at_start);
      end
    end
    cfg_freeze = 1'b0;
    tests_run++;
    if (err_count !== '0 || ref_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL freeze_end: got errs %0d ref %b expected 0 1", err_count, ref_valid);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    ref_clear = 1'b0;
    tests_run++;
    if (state !== 2'd0 || {ref_valid, buf_we_en, cmp_valid} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL clear_start: got state %0d ref/we/cmp %b expected 0 000", state, {ref_valid, buf_we_en, cmp_valid});
    end
    send_beats(1, 15, 1'b0);
    tests_run++;
    if (state !== 2'd0 || err_count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL clear_orphan: got state %0d errs %0d expected 0 0", state, err_count);
    end
    send_beats(0, 15, 1'b0);
    tests_run++;
    if (st_at_start !== 2'd1 || we_at_start !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clear_next: got state %0d we %b expected 1 1", st_at_start, we_at_start);
    end
    tests_run++;
    if (state !== 2'd2 || ref_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clear_done: got state %0d ref %b expected 2 1", state, ref_valid);
    end
  endtask

  task automatic test_cke_and_reset();
    do_reset();
    send_beats(0, 5, 1'b0);
    cke = 1'b0;
    s_valid = 1'b1;
    s_de = 1'b1;
    s_row_first = 1'b1;
    s_row_last = 1'b1;
    s_col_first = 1'b1;
    s_col_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (state !== 2'd1 || buf_we_en !== 1'b1 || frame_start !== 1'b0 || frame_end !== 1'b0 || frame_count !== FB'(1)) begin
        tests_failed++;
        $display("[TB] FAIL cke_hold cycle %0d: got state %0d we %b fs %b fe %b frames %0d expected 1 1 0 0 1",
                 c, state, buf_we_en, frame_start, frame_end, frame_count);
      end
    end
    cke = 1'b1;
    send_beats(6, 15, 1'b0);
    tests_run++;
    if (state !== 2'd2 || ref_valid !== 1'b1 || err_count !== '0 || frame_end !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL cke_done: got state %0d ref %b errs %0d fe %b expected 2 1 0 1", state, ref_valid, err_count, frame_end);
    end
    send_beats(0, 7, 1'b0);
    tests_run++;
    if (st_at_start !== 2'd3) begin tests_failed++; $display("[TB] FAIL mid_update: got %0d expected 3", st_at_start); end
    do_reset();
    tests_run++;
    if (state !== 2'd0 || {buf_we_en, ref_valid, cmp_valid, frame_start, frame_end} !== 5'b0 ||
        frame_count !== '0 || err_count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset: got state %0d flags %b frames %0d errs %0d expected 0 00000 0 0",
               state, {buf_we_en, ref_valid, cmp_valid, frame_start, frame_end}, frame_count, err_count);
    end
    send_beats(8, 15, 1'b0);
    tests_run++;
    if (state !== 2'd0 || err_count !== '0 || ref_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL orphan_end: got state %0d errs %0d ref %b expected 0 0 0", state, err_count, ref_valid);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_interval();
    test_fill_restart();
    test_short_frame();
    test_freeze_clear();
    test_cke_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
